nios2_debug_ocimem_arbiter: RTL and testbench

Sysclk-domain controller that shares the single-port on-chip debug memory (OCI RAM, 256×32) between the JTAG debug path and the CPU's debug Avalon slave. It turns the debug slave's `take_action_ocimem_*` strobes and `jdo` payload into sequenced RAM reads and writes, maintains the monitor address/data registers (`MonAReg`/`MonDReg`), and reports `monitor_ready`/`monitor_error` back to the debug slave. CPU Avalon accesses to the same RAM are arbitrated fairly against JTAG traffic.

---
 rtl/nios2_debug_pkg.sv | 28 ++
 rtl/nios2_debug_ocimem_arbiter_jtag_req_latch.sv | 68 ++++++
 rtl/nios2_debug_ocimem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_nios2_debug_ocimem_arbiter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios2_debug_pkg.sv
// Shared types and constants for the Nios II debug OCI memory arbiter.
package nios2_debug_pkg;

   localparam int unsigned OCIMEM_DEPTH  = 256;

   // jdo field positions
   localparam int unsigned JDO_ADDR_HI  = 25;
   localparam int unsigned JDO_ADDR_LO  = 18;
   localparam int unsigned JDO_RD_BIT   = 17;
   localparam int unsigned JDO_WDATA_HI = 34;
   localparam int unsigned JDO_WDATA_LO = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_J_RD,
      ST_J_RDW,
      ST_J_WR,
      ST_C_RD,
      ST_C_RDW,
      ST_C_WR
   } ocimem_state_t;

   typedef enum logic {
      JOP_READ,
      JOP_WRITE
   } jtag_op_t;

endpackage

// File: rtl/nios2_debug_ocimem_arbiter_jtag_req_latch.sv
// JTAG strobe decode, single pending request slot, overrun detection and
// the sticky monitor_error flag.
module nios2_debug_jtag_req_latch
   import nios2_debug_pkg::*;
#(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [37:0]       jdo,
   input  logic              take_action_ocimem_a,
   input  logic              take_no_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   input  logic [ADDR_W-1:0] cur_addr,
   input  logic              complete,
   output logic              pend_valid,
   output jtag_op_t          pend_op,
   output logic [ADDR_W-1:0] pend_addr,
   output logic [DATA_W-1:0] pend_data,
   output logic              accept,
   output logic              load_addr,
   output logic [ADDR_W-1:0] load_value,
   output logic              monitor_error
);

   logic any_strobe;
   logic busy;
   logic queue_rd;
   logic queue_wr;
   logic unused_jdo;

   assign any_strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
   // A slot that completes this cycle can take a new strobe on the same edge.
   assign busy       = pend_valid & ~complete;
   assign accept     = any_strobe & ~busy;
   assign load_addr  = accept & take_action_ocimem_a;
   assign load_value = jdo[JDO_ADDR_HI:JDO_ADDR_LO];
   assign queue_rd   = accept & (take_action_ocimem_a ? jdo[JDO_RD_BIT] : take_no_action_ocimem_a);
   assign queue_wr   = accept & ~take_action_ocimem_a & ~take_no_action_ocimem_a & take_action_ocimem_b;
   assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

   // Pending slot fill/drain and sticky overrun flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend_valid    <= 1'b0;
         pend_op       <= JOP_READ;
         pend_addr     <= '0;
         pend_data     <= '0;
         monitor_error <= 1'b0;
      end else begin
         if (queue_rd || queue_wr) begin
            pend_valid <= 1'b1;
            pend_op    <= queue_wr ? JOP_WRITE : JOP_READ;
            pend_addr  <= take_action_ocimem_a ? load_value : cur_addr;
            pend_data  <= jdo[JDO_WDATA_HI:JDO_WDATA_LO];
         end else if (complete) begin
            pend_valid <= 1'b0;
         end
         if (any_strobe && busy) begin
            monitor_error <= 1'b1;
         end else if (load_addr) begin
            monitor_error <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/nios2_debug_ocimem_arbiter.sv
// Shares the single-port OCI RAM between JTAG monitor requests and the CPU
// debug Avalon slave, with round-robin arbitration on contention.
module nios2_debug_ocimem_arbiter
   import nios2_debug_pkg::*;
#(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [37:0]       jdo,
   input  logic              take_action_ocimem_a,
   input  logic              take_no_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   output logic [DATA_W-1:0] MonDReg,
   output logic              monitor_ready,
   output logic              monitor_error,
   input  logic [ADDR_W-1:0] av_address,
   input  logic              av_read,
   input  logic              av_write,
   input  logic [DATA_W-1:0] av_writedata,
   input  logic [3:0]        av_byteenable,
   output logic [DATA_W-1:0] av_readdata,
   output logic              av_waitrequest,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic [3:0]        ram_be,
   output logic              ram_we,
   output logic              ram_re,
   input  logic [DATA_W-1:0] ram_rdata
);

   ocimem_state_t     state;
   logic [ADDR_W-1:0] mon_a_reg;
   logic [ADDR_W-1:0] mon_a_step;
   logic              favour_cpu;
   logic              j_done;
   logic              cpu_req;
   logic              grant_j;
   logic              grant_c;

   logic              pend_valid;
   jtag_op_t          pend_op;
   logic [ADDR_W-1:0] pend_addr;
   logic [DATA_W-1:0] pend_data;
   logic              accept;
   logic              load_addr;
   logic [ADDR_W-1:0] load_value;

   assign j_done      = (state == ST_J_RDW) || (state == ST_J_WR);
   // Address a strobe accepted now should target: the post-increment value
   // when the current JTAG access retires on this same edge.
   assign mon_a_step  = j_done ? mon_a_reg + ADDR_W'(1) : mon_a_reg;
   assign cpu_req     = av_read | av_write;
   assign grant_j     = pend_valid & (~cpu_req | ~favour_cpu);
   assign grant_c     = cpu_req & ~grant_j;
   assign av_readdata = (state == ST_C_RDW) ? ram_rdata : '0;

   nios2_debug_jtag_req_latch #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_req_latch (
      .clk                     (clk),
      .reset_n                 (reset_n),
      .jdo                     (jdo),
      .take_action_ocimem_a    (take_action_ocimem_a),
      .take_no_action_ocimem_a (take_no_action_ocimem_a),
      .take_action_ocimem_b    (take_action_ocimem_b),
      .cur_addr                (mon_a_step),
      .complete                (j_done),
      .pend_valid              (pend_valid),
      .pend_op                 (pend_op),
      .pend_addr               (pend_addr),
      .pend_data               (pend_data),
      .accept                  (accept),
      .load_addr               (load_addr),
      .load_value              (load_value),
      .monitor_error           (monitor_error)
   );

   // Access sequencer: arbitration in IDLE, registered RAM and wait outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= ST_IDLE;
         favour_cpu     <= 1'b0;
         ram_addr       <= '0;
         ram_wdata      <= '0;
         ram_be         <= '0;
         ram_we         <= 1'b0;
         ram_re         <= 1'b0;
         av_waitrequest <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               if (grant_j) begin
                  favour_cpu <= 1'b1;
                  ram_addr   <= pend_addr;
                  if (pend_op == JOP_WRITE) begin
                     state     <= ST_J_WR;
                     ram_we    <= 1'b1;
                     ram_wdata <= pend_data;
                     ram_be    <= '1;
                  end else begin
                     state  <= ST_J_RD;
                     ram_re <= 1'b1;
                  end
               end else if (grant_c) begin
                  favour_cpu <= 1'b0;
                  ram_addr   <= av_address;
                  if (av_write) begin
                     state          <= ST_C_WR;
                     ram_we         <= 1'b1;
                     ram_wdata      <= av_writedata;
                     ram_be         <= av_byteenable;
                     av_waitrequest <= 1'b0;
                  end else begin
                     state  <= ST_C_RD;
                     ram_re <= 1'b1;
                  end
               end
            end
            ST_J_RD: begin
               state  <= ST_J_RDW;
               ram_re <= 1'b0;
            end
            ST_C_RD: begin
               state          <= ST_C_RDW;
               ram_re         <= 1'b0;
               av_waitrequest <= 1'b0;
            end
            ST_J_RDW, ST_J_WR, ST_C_RDW, ST_C_WR: begin
               state          <= ST_IDLE;
               ram_we         <= 1'b0;
               av_waitrequest <= 1'b1;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Monitor address/data registers and the ready handshake.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mon_a_reg     <= '0;
         MonDReg       <= '0;
         monitor_ready <= 1'b0;
      end else begin
         mon_a_reg <= load_addr ? load_value : mon_a_step;
         if (state == ST_J_RDW) begin
            MonDReg <= ram_rdata;
         end
         if (accept) begin
            monitor_ready <= load_addr & ~jdo[JDO_RD_BIT];
         end else if (j_done) begin
            monitor_ready <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_nios2_debug_ocimem_arbiter.sv
// Randomised scoreboard bench for the OCI memory arbiter with a behavioural
// RAM and a transaction-level reference model.
module tb_nios2_debug_ocimem_arbiter;

   typedef struct packed {
      logic        rd;
      logic [31:0] d;
   } cexp_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [37:0] jdo = '0;
   logic        take_action_ocimem_a = 1'b0;
   logic        take_no_action_ocimem_a = 1'b0;
   logic        take_action_ocimem_b = 1'b0;
   logic [31:0] MonDReg;
   logic        monitor_ready;
   logic        monitor_error;
   logic [7:0]  av_address = '0;
   logic        av_read = 1'b0;
   logic        av_write = 1'b0;
   logic [31:0] av_writedata = '0;
   logic [3:0]  av_byteenable = '0;
   logic [31:0] av_readdata;
   logic        av_waitrequest;
   logic [7:0]  ram_addr;
   logic [31:0] ram_wdata;
   logic [3:0]  ram_be;
   logic        ram_we;
   logic        ram_re;
   logic [31:0] ram_rdata;

   always #5 clk = ~clk;

   nios2_debug_ocimem_arbiter #(
      .ADDR_W (8),
      .DATA_W (32)
   ) dut (
      .clk                     (clk),
      .reset_n                 (reset_n),
      .jdo                     (jdo),
      .take_action_ocimem_a    (take_action_ocimem_a),
      .take_no_action_ocimem_a (take_no_action_ocimem_a),
      .take_action_ocimem_b    (take_action_ocimem_b),
      .MonDReg                 (MonDReg),
      .monitor_ready           (monitor_ready),
      .monitor_error           (monitor_error),
      .av_address              (av_address),
      .av_read                 (av_read),
      .av_write                (av_write),
      .av_writedata            (av_writedata),
      .av_byteenable           (av_byteenable),
      .av_readdata             (av_readdata),
      .av_waitrequest          (av_waitrequest),
      .ram_addr                (ram_addr),
      .ram_wdata               (ram_wdata),
      .ram_be                  (ram_be),
      .ram_we                  (ram_we),
      .ram_re                  (ram_re),
      .ram_rdata               (ram_rdata)
   );

   function automatic logic [31:0] init_word(input int i);
      return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A1234;
   endfunction

   // Behavioural single-port RAM, one-cycle read latency
   logic [31:0] mem [256];
   logic [31:0] rdq = '0;
   logic        fill = 1'b1;
   int unsigned ram_acc = 0;
   assign ram_rdata = rdq;

   always @(posedge clk) begin
      if (fill) begin
         for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      end else begin
         if (ram_we)
            for (int b = 0; b < 4; b++)
               if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
         if (ram_re) rdq <= mem[ram_addr];
         if (ram_we || ram_re) ram_acc <= ram_acc + 1;
      end
   end

   // Reference model state
   logic [31:0] ref_mem [256];
   logic [7:0]  ref_a = '0;
   logic [31:0] ref_d = '0;
   logic        ref_err = 1'b0;
   logic        ref_ready = 1'b0;
   logic        cpu_tie = 1'b0;   // 1: CPU wins the next tie (JTAG was served last)

   logic [31:0] jq [$];
   cexp_t       cq [$];

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic flag(input string name);
      checks++;
      errors++;
      $display("FAIL %s", name);
   endtask

   // Monitor: pops expected values whenever the DUT presents a response
   logic  prev_ready = 1'b0;
   cexp_t mon_e;
   always @(negedge clk) begin
      if (!reset_n) begin
         prev_ready <= 1'b0;
      end else begin
         if (monitor_ready && !prev_ready) begin
            if (jq.size() == 0) flag("jtag_unexpected_ready");
            else check("jtag_mondreg", MonDReg, jq.pop_front());
         end
         prev_ready <= monitor_ready;
         if ((av_read || av_write) && !av_waitrequest) begin
            if (cq.size() == 0) begin
               flag("cpu_unexpected_ack");
            end else begin
               mon_e = cq.pop_front();
               check("cpu_op_kind", {31'b0, av_write}, {31'b0, ~mon_e.rd});
               if (mon_e.rd) check("cpu_readdata", av_readdata, mon_e.d);
            end
         end
      end
   end

   task automatic strobe(input int kind, input logic [37:0] j);
      @(posedge clk); #1;
      jdo = j;
      case (kind)
         0: take_action_ocimem_a = 1'b1;
         1: take_no_action_ocimem_a = 1'b1;
         default: take_action_ocimem_b = 1'b1;
      endcase
      @(posedge clk); #1;
      take_action_ocimem_a = 1'b0;
      take_no_action_ocimem_a = 1'b0;
      take_action_ocimem_b = 1'b0;
   endtask

   task automatic wait_ready(input string name);
      int n = 0;
      while (n < 30) begin
         @(negedge clk);
         if (monitor_ready) break;
         n++;
      end
      if (!monitor_ready) flag({name, "_ready_timeout"});
      check({name, "_error"}, {31'b0, monitor_error}, {31'b0, ref_err});
   endtask

   task automatic j_load(input logic [7:0] ad, input logic rd);
      logic [37:0] j = 38'($urandom);
      int unsigned acc0;
      j[25:18] = ad;
      j[17] = rd;
      ref_a = ad;
      ref_err = 1'b0;
      if (rd) begin
         ref_d = ref_mem[ad];
         ref_a = ad + 8'd1;
         jq.push_back(ref_d);
         cpu_tie = 1'b1;
      end else if (!ref_ready) begin
         jq.push_back(ref_d);
      end
      ref_ready = 1'b1;
      acc0 = ram_acc;
      strobe(0, j);
      wait_ready("load");
      if (!rd) begin
         repeat (3) @(negedge clk);
         check("load_no_ram_access", ram_acc, acc0);
      end
   endtask

   task automatic j_read();
      ref_d = ref_mem[ref_a];
      ref_a = ref_a + 8'd1;
      jq.push_back(ref_d);
      ref_ready = 1'b1;
      cpu_tie = 1'b1;
      strobe(1, 38'($urandom));
      wait_ready("jread");
   endtask

   task automatic j_write(input logic [31:0] d);
      logic [37:0] j = 38'($urandom);
      j[34:3] = d;
      ref_mem[ref_a] = d;
      ref_a = ref_a + 8'd1;
      jq.push_back(ref_d);
      ref_ready = 1'b1;
      cpu_tie = 1'b1;
      strobe(2, j);
      wait_ready("jwrite");
   endtask

   task automatic cpu_op(input logic wr, input logic both, input logic [7:0] ad,
                         input logic [31:0] d, input logic [3:0] be, input string name);
      cexp_t e;
      int n = 0;
      e.rd = ~wr;
      e.d = ref_mem[ad];
      if (wr)
         for (int b = 0; b < 4; b++)
            if (be[b]) ref_mem[ad][8*b +: 8] = d[8*b +: 8];
      cq.push_back(e);
      cpu_tie = 1'b0;
      @(posedge clk); #1;
      av_address = ad;
      av_write = wr;
      av_read = ~wr | both;
      av_writedata = d;
      av_byteenable = be;
      do begin
         @(negedge clk);
         n++;
         if (n == 1) check({name, "_rdata_idle"}, av_readdata, 32'h0);
      end while (av_waitrequest && n < 20);
      check({name, "_latency"}, n, wr ? 2 : 3);
      @(posedge clk); #1;
      av_read = 1'b0;
      av_write = 1'b0;
   endtask

   task automatic contend(input logic [7:0] cad, input string name);
      logic  jfirst = ~cpu_tie;
      cexp_t e;
      int    n = 0;
      ref_d = ref_mem[ref_a];
      ref_a = ref_a + 8'd1;
      jq.push_back(ref_d);
      ref_ready = 1'b1;
      e.rd = 1'b1;
      e.d = ref_mem[cad];
      cq.push_back(e);
      cpu_tie = jfirst ? 1'b0 : 1'b1;
      @(posedge clk); #1;
      jdo = 38'($urandom);
      take_no_action_ocimem_a = 1'b1;
      @(posedge clk); #1;
      take_no_action_ocimem_a = 1'b0;
      av_address = cad;
      av_read = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (av_waitrequest && n < 20);
      check({name, "_cpu_latency"}, n, jfirst ? 6 : 3);
      @(posedge clk); #1;
      av_read = 1'b0;
      wait_ready(name);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] d1, d2;
      for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
      @(posedge clk); #1;
      fill = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_during_waitreq", {31'b0, av_waitrequest}, 32'h1);
      check("rst_during_ready", {31'b0, monitor_ready}, 32'h0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(negedge clk);
      check("rst_mondreg", MonDReg, 32'h0);
      check("rst_ready", {31'b0, monitor_ready}, 32'h0);
      check("rst_error", {31'b0, monitor_error}, 32'h0);
      check("rst_waitreq", {31'b0, av_waitrequest}, 32'h1);
      check("rst_readdata", av_readdata, 32'h0);
      check("rst_ram_ctl", {24'b0, ram_addr}, 32'h0);
      check("rst_ram_en", {30'b0, ram_we, ram_re}, 32'h0);

      // Load without read, write, then read back the incremented address
      j_load(8'h10, 1'b0);
      j_write(32'hDEADBEEF);
      j_read();

      // Read with wrap at 0xFF
      j_load(8'hFF, 1'b1);
      j_read();

      // Contention: CPU served last -> JTAG first; JTAG served last -> CPU first
      cpu_op(1'b0, 1'b0, 8'h20, 32'h0, 4'h0, "cpu_rd20");
      contend(8'h20, "contend_jfirst");
      j_read();
      contend(8'h20, "contend_cfirst");

      // Overrun: second write strobe one cycle later is dropped
      d1 = $urandom;
      d2 = $urandom;
      ref_mem[ref_a] = d1;
      ref_a = ref_a + 8'd1;
      jq.push_back(ref_d);
      ref_err = 1'b1;
      ref_ready = 1'b1;
      cpu_tie = 1'b1;
      @(posedge clk); #1;
      jdo = 38'($urandom);
      jdo[34:3] = d1;
      take_action_ocimem_b = 1'b1;
      @(posedge clk); #1;
      jdo[34:3] = d2;
      @(posedge clk); #1;
      take_action_ocimem_b = 1'b0;
      wait_ready("overrun");
      j_read();
      j_load(8'h40, 1'b0);

      // Strobe landing in the completion cycle is accepted
      d1 = $urandom;
      d2 = $urandom;
      ref_mem[ref_a] = d1;
      ref_mem[ref_a + 8'd1] = d2;
      ref_a = ref_a + 8'd2;
      jq.push_back(ref_d);
      @(posedge clk); #1;
      jdo = 38'($urandom);
      jdo[34:3] = d1;
      take_action_ocimem_b = 1'b1;
      @(posedge clk); #1;
      take_action_ocimem_b = 1'b0;
      @(posedge clk); #1;
      jdo[34:3] = d2;
      take_action_ocimem_b = 1'b1;
      @(posedge clk); #1;
      take_action_ocimem_b = 1'b0;
      wait_ready("complete_cycle");
      j_read();

      // CPU byte write then read back
      cpu_op(1'b1, 1'b0, 8'h05, 32'h0000AB00, 4'b0010, "cpu_bytewr");
      cpu_op(1'b0, 1'b0, 8'h05, 32'h0, 4'h0, "cpu_rd05");

      // Random serialized traffic
      for (int k = 0; k < 60; k++) begin
         case ($urandom_range(0, 5))
            0: j_load(8'($urandom), 1'b1);
            1: j_load(8'($urandom), 1'b0);
            2: j_read();
            3: j_write($urandom);
            4: cpu_op(1'b0, 1'b0, 8'($urandom), 32'h0, 4'h0, "rnd_cpu_rd");
            default: cpu_op(1'b1, 1'($urandom), 8'($urandom), $urandom, 4'($urandom), "rnd_cpu_wr");
         endcase
      end

      // Reset during J_RDW
      strobe(1, 38'($urandom));
      repeat (3) @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("midrst_mondreg", MonDReg, 32'h0);
      check("midrst_ready", {31'b0, monitor_ready}, 32'h0);
      check("midrst_waitreq", {31'b0, av_waitrequest}, 32'h1);
      check("midrst_ram_en", {30'b0, ram_we, ram_re}, 32'h0);
      jq.delete();
      cq.delete();
      ref_a = '0;
      ref_d = '0;
      ref_err = 1'b0;
      ref_ready = 1'b0;
      cpu_tie = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      cpu_op(1'b0, 1'b0, 8'h33, 32'h0, 4'h0, "postrst_cpu_rd");
      j_read();

      repeat (4) @(negedge clk);
      check("jq_drained", jq.size(), 32'h0);
      check("cq_drained", cq.size(), 32'h0);
      for (int i = 0; i < 256; i++) check("ram_final", mem[i], ref_mem[i]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
